// File: rtl/dbg_pkg.sv
// Shared encodings for the CPU debug/run controller: command opcodes,
// controller states, halt causes and read-source selection.
package dbg_pkg;

  typedef enum logic [2:0] {
    OP_RUN      = 3'd0,
    OP_STEP     = 3'd1,
    OP_HALT     = 3'd2,
    OP_SET_BP   = 3'd3,
    OP_CLR_BP   = 3'd4,
    OP_READ_RF  = 3'd5,
    OP_READ_MEM = 3'd6,
    OP_NOP      = 3'd7
  } dbg_op_e;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_READ = 2'd3
  } dbg_state_e;

  typedef enum logic [1:0] {
    CAUSE_RESET      = 2'd0,
    CAUSE_HALT_CMD   = 2'd1,
    CAUSE_BREAKPOINT = 2'd2,
    CAUSE_STEP_DONE  = 2'd3
  } halt_cause_e;

  typedef enum logic {
    SRC_RF  = 1'b0,
    SRC_MEM = 1'b1
  } rd_src_e;

  function automatic logic is_read_op(input dbg_op_e op);
    return (op == OP_READ_RF) || (op == OP_READ_MEM);
  endfunction

endpackage

// File: rtl/cpu_debug_ctrl_bp_match.sv
// PC breakpoint slots: each slot holds a valid bit and a 32-bit PC and
// reports whether the current fetch PC matches any valid slot.
module bp_match #(
  parameter int NUM_BP = 4,
  parameter int BPW    = $clog2(NUM_BP)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            set_i,
  input  logic            clr_i,
  input  logic [BPW-1:0]  idx_i,
  input  logic [31:0]     wr_pc_i,
  input  logic [31:0]     pc_i,
  output logic            hit_o
);

  logic [NUM_BP-1:0] valid_q;
  logic [31:0]       slot_pc_q [NUM_BP];
  logic [NUM_BP-1:0] hit_vec;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_BP; i++) begin
        slot_pc_q[i] <= '0;
      end
    end else if (set_i) begin
      valid_q[idx_i]   <= 1'b1;
      slot_pc_q[idx_i] <= wr_pc_i;
    end else if (clr_i) begin
      valid_q[idx_i] <= 1'b0;
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      hit_vec[i] = valid_q[i] && (slot_pc_q[i] == pc_i);
    end
  end

  assign hit_o = |hit_vec;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// Debug/run controller: gates the CPU clock enable for run/halt/step with
// PC breakpoints, and serves register-file/data-memory debug reads.
module cpu_debug_ctrl
  import dbg_pkg::*;
#(
  parameter int NUM_BP = 4,
  parameter int BPW    = $clog2(NUM_BP)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            cmd_valid_i,
  output logic            cmd_ready_o,
  input  logic [2:0]      cmd_op_i,
  input  logic [31:0]     cmd_arg_i,
  input  logic [BPW-1:0]  cmd_idx_i,
  input  logic [31:0]     pc_out_i,
  output logic            cpu_en_o,
  output logic [7:0]      m_rf_addr_o,
  input  logic [31:0]     rf_data_i,
  input  logic [31:0]     m_data_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [31:0]     rsp_data_o,
  output logic            rsp_err_o,
  output logic            halted_o,
  output logic [1:0]      halt_cause_o
);

  dbg_state_e  state_q;
  halt_cause_e cause_q;
  rd_src_e     src_q;
  logic        skip_q;
  logic [31:0] step_cnt_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;
  logic [7:0]  rf_addr_q;

  dbg_op_e     op;
  logic        cmd_fire;
  logic        bp_raw;
  logic        bp_hit;
  logic        cpu_en;

  assign op          = dbg_op_e'(cmd_op_i);
  assign cmd_ready_o = ((state_q == ST_HALT) || (state_q == ST_RUN)) && !rsp_valid_q;
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;

  bp_match #(
    .NUM_BP (NUM_BP),
    .BPW    (BPW)
  ) u_bp_match (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .set_i   (cmd_fire && (op == OP_SET_BP)),
    .clr_i   (cmd_fire && (op == OP_CLR_BP)),
    .idx_i   (cmd_idx_i),
    .wr_pc_i (cmd_arg_i),
    .pc_i    (pc_out_i),
    .hit_o   (bp_raw)
  );

  // skip masks the breakpoint we resumed from until the CPU has moved once.
  assign bp_hit = bp_raw && !skip_q;

  always_comb begin
    cpu_en = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP: cpu_en = !bp_hit;
      default:         cpu_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_HALT;
      cause_q     <= CAUSE_RESET;
      src_q       <= SRC_RF;
      skip_q      <= 1'b0;
      step_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      rf_addr_q   <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
      if (cpu_en) begin
        skip_q <= 1'b0;
      end

      case (state_q)
        ST_HALT: begin
          if (cmd_fire) begin
            case (op)
              OP_RUN: begin
                state_q <= ST_RUN;
                skip_q  <= 1'b1;
              end
              OP_STEP: begin
                state_q    <= ST_STEP;
                skip_q     <= 1'b1;
                step_cnt_q <= (cmd_arg_i == 32'd0) ? 32'd1 : cmd_arg_i;
              end
              OP_READ_RF, OP_READ_MEM: begin
                state_q   <= ST_READ;
                rf_addr_q <= cmd_arg_i[7:0];
                src_q     <= (op == OP_READ_MEM) ? SRC_MEM : SRC_RF;
              end
              default: ;
            endcase
          end
        end

        ST_RUN: begin
          // A HALT command wins over a breakpoint seen in the same cycle.
          if (cmd_fire && (op == OP_HALT)) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_HALT_CMD;
          end else if (bp_hit) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_BREAKPOINT;
          end
          if (cmd_fire && is_read_op(op)) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_data_q  <= '0;
          end
        end

        ST_STEP: begin
          if (bp_hit) begin
            state_q <= ST_HALT;
            cause_q <= CAUSE_BREAKPOINT;
          end else begin
            step_cnt_q <= step_cnt_q - 32'd1;
            if (step_cnt_q == 32'd1) begin
              state_q <= ST_HALT;
              cause_q <= CAUSE_STEP_DONE;
            end
          end
        end

        ST_READ: begin
          rsp_data_q  <= (src_q == SRC_MEM) ? m_data_i : rf_data_i;
          rsp_err_q   <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_HALT;
        end

        default: state_q <= ST_HALT;
      endcase
    end
  end

  assign cpu_en_o     = cpu_en;
  assign m_rf_addr_o  = rf_addr_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign halted_o     = (state_q == ST_HALT) || (state_q == ST_READ);
  assign halt_cause_o = cause_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl: a PC model that advances by 4 on each
// enabled cycle, plus a queue of expected read responses.
module tb_cpu_debug_ctrl;
  import dbg_pkg::*;

  localparam int NUM_BP = 4;
  localparam int BPW    = 2;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic           clock;
  logic           resetN;
  logic           cmdValid;
  logic           cmdReady;
  logic [2:0]     cmdOp;
  logic [31:0]    cmdArg;
  logic [BPW-1:0] cmdIdx;
  logic [31:0]    pcOut;
  logic           cpuEn;
  logic [7:0]     mRfAddr;
  logic [31:0]    rfData;
  logic [31:0]    mData;
  logic           rspValid;
  logic           rspReady;
  logic [31:0]    rspData;
  logic           rspErr;
  logic           halted;
  logic [1:0]     haltCause;

  int   checks = 0;
  int   errors = 0;
  rsp_t expQ[$];

  cpu_debug_ctrl #(
    .NUM_BP (NUM_BP),
    .BPW    (BPW)
  ) dut (
    .clk_i        (clock),
    .rst_ni       (resetN),
    .cmd_valid_i  (cmdValid),
    .cmd_ready_o  (cmdReady),
    .cmd_op_i     (cmdOp),
    .cmd_arg_i    (cmdArg),
    .cmd_idx_i    (cmdIdx),
    .pc_out_i     (pcOut),
    .cpu_en_o     (cpuEn),
    .m_rf_addr_o  (mRfAddr),
    .rf_data_i    (rfData),
    .m_data_i     (mData),
    .rsp_valid_o  (rspValid),
    .rsp_ready_i  (rspReady),
    .rsp_data_o   (rspData),
    .rsp_err_o    (rspErr),
    .halted_o     (halted),
    .halt_cause_o (haltCause)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in for the CPU fetch stage: PC moves one word per enabled cycle.
  always @(posedge clock or negedge resetN) begin
    if (!resetN) pcOut <= 32'h0;
    else if (cpuEn) pcOut <= pcOut + 32'd4;
  end

  // Hard time limit so a stuck DUT can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one command, confirms it is accepted, and returns one cycle later.
  task automatic applyStimulus(input dbg_op_e op, input logic [31:0] arg,
                               input logic [BPW-1:0] idx, input string tag);
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdArg   = arg;
    cmdIdx   = idx;
    #1;
    checkOutput({tag, "_cmd_ready"}, 32'(cmdReady), 32'd1);
    nextCycle();
    cmdValid = 1'b0;
    cmdOp    = OP_NOP;
    #1;
  endtask

  // Accepts the pending response and compares it against the queue head.
  task automatic consumeResponse(input string tag);
    rsp_t e;
    int   n;
    rspReady = 1'b1;
    #1;
    n = 0;
    while (!rspValid && n < 10) begin
      nextCycle();
      n++;
    end
    checkOutput({tag, "_rsp_valid"}, 32'(rspValid), 32'd1);
    checkOutput({tag, "_sb_nonempty"}, 32'(expQ.size() != 0), 32'd1);
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      checkOutput({tag, "_rsp_data"}, rspData, e.data);
      checkOutput({tag, "_rsp_err"}, 32'(rspErr), 32'(e.err));
    end
    nextCycle();
    rspReady = 1'b0;
    #1;
    checkOutput({tag, "_rsp_cleared"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    logic [31:0] p0;
    logic [31:0] target;
    int          n;

    resetN   = 1'b0;
    cmdValid = 1'b0;
    cmdOp    = OP_NOP;
    cmdArg   = '0;
    cmdIdx   = '0;
    rfData   = '0;
    mData    = '0;
    rspReady = 1'b0;
    repeat (3) nextCycle();
    resetN = 1'b1;
    #1;

    // Reset state.
    checkOutput("rst_halted", 32'(halted), 32'd1);
    checkOutput("rst_cpu_en", 32'(cpuEn), 32'd0);
    checkOutput("rst_cause", 32'(haltCause), 32'(CAUSE_RESET));
    checkOutput("rst_cmd_ready", 32'(cmdReady), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rst_m_rf_addr", 32'(mRfAddr), 32'd0);

    // Breakpoint at 0x10, run from PC 0 into it.
    applyStimulus(OP_SET_BP, 32'h10, 2'd0, "setbp0");
    applyStimulus(OP_RUN, 32'h0, 2'd0, "run1");
    checkOutput("run1_cpu_en", 32'(cpuEn), 32'd1);
    checkOutput("run1_halted", 32'(halted), 32'd0);
    n = 0;
    while (pcOut != 32'h10 && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("bp0_pc", pcOut, 32'h10);
    checkOutput("bp0_cpu_en_low", 32'(cpuEn), 32'd0);
    nextCycle();
    checkOutput("bp0_halted", 32'(halted), 32'd1);
    checkOutput("bp0_cause", 32'(haltCause), 32'(CAUSE_BREAKPOINT));
    checkOutput("bp0_pc_held", pcOut, 32'h10);

    // Resume from the breakpoint without re-halting on it.
    applyStimulus(OP_RUN, 32'h0, 2'd0, "run2");
    checkOutput("run2_cpu_en_at_bp", 32'(cpuEn), 32'd1);
    nextCycle();
    checkOutput("run2_pc_past_bp", pcOut, 32'h14);
    applyStimulus(OP_HALT, 32'h0, 2'd0, "halt1");
    checkOutput("halt1_halted", 32'(halted), 32'd1);
    checkOutput("halt1_cause", 32'(haltCause), 32'(CAUSE_HALT_CMD));
    checkOutput("halt1_cpu_en", 32'(cpuEn), 32'd0);

    // STEP 5 then STEP 0.
    p0 = pcOut;
    applyStimulus(OP_STEP, 32'd5, 2'd0, "step5");
    n = 0;
    while (!halted && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("step5_pc_delta", pcOut - p0, 32'd20);
    checkOutput("step5_cause", 32'(haltCause), 32'(CAUSE_STEP_DONE));
    p0 = pcOut;
    applyStimulus(OP_STEP, 32'd0, 2'd0, "step0");
    n = 0;
    while (!halted && n < 20) begin
      nextCycle();
      n++;
    end
    checkOutput("step0_pc_delta", pcOut - p0, 32'd4);
    checkOutput("step0_cause", 32'(haltCause), 32'(CAUSE_STEP_DONE));

    // READ_RF with a back-pressured response.
    rfData = 32'h1234_5678;
    mData  = 32'hDEAD_BEEF;
    expQ.push_back('{data: 32'h1234_5678, err: 1'b0});
    applyStimulus(OP_READ_RF, 32'd3, 2'd0, "readrf");
    checkOutput("readrf_addr", 32'(mRfAddr), 32'd3);
    checkOutput("readrf_no_rsp_yet", 32'(rspValid), 32'd0);
    checkOutput("readrf_halted", 32'(halted), 32'd1);
    nextCycle();
    checkOutput("readrf_rsp_valid", 32'(rspValid), 32'd1);
    rfData = 32'h0;
    for (int i = 0; i < 4; i++) begin
      nextCycle();
      checkOutput("readrf_hold_data", rspData, 32'h1234_5678);
      checkOutput("readrf_hold_cmd_ready", 32'(cmdReady), 32'd0);
    end
    consumeResponse("readrf");

    // READ_MEM from HALT selects the data-memory source.
    mData = 32'hCAFE_F00D;
    rfData = 32'h1111_2222;
    expQ.push_back('{data: 32'hCAFE_F00D, err: 1'b0});
    applyStimulus(OP_READ_MEM, 32'h40, 2'd0, "readmem");
    checkOutput("readmem_addr", 32'(mRfAddr), 32'h40);
    consumeResponse("readmem");

    // READ_MEM while running is rejected and the CPU keeps going.
    applyStimulus(OP_RUN, 32'h0, 2'd0, "run3");
    expQ.push_back('{data: 32'h0, err: 1'b1});
    applyStimulus(OP_READ_MEM, 32'd5, 2'd0, "runread");
    checkOutput("runread_cpu_en", 32'(cpuEn), 32'd1);
    checkOutput("runread_cmd_ready", 32'(cmdReady), 32'd0);
    p0 = pcOut;
    nextCycle();
    checkOutput("runread_pc_moves", pcOut, p0 + 32'd4);
    consumeResponse("runread");

    // HALT command in the same cycle as a breakpoint hit.
    target = pcOut + 32'h20;
    applyStimulus(OP_SET_BP, target, 2'd1, "setbp1");
    n = 0;
    while (pcOut != target && n < 30) begin
      nextCycle();
      n++;
    end
    checkOutput("bp1_pc", pcOut, target);
    cmdValid = 1'b1;
    cmdOp    = OP_HALT;
    #1;
    checkOutput("bp1_cpu_en_low", 32'(cpuEn), 32'd0);
    checkOutput("bp1_cmd_ready", 32'(cmdReady), 32'd1);
    nextCycle();
    cmdValid = 1'b0;
    cmdOp    = OP_NOP;
    #1;
    checkOutput("bp1_halted", 32'(halted), 32'd1);
    checkOutput("bp1_cause_halt_wins", 32'(haltCause), 32'(CAUSE_HALT_CMD));

    // Reset in the middle of a long STEP.
    applyStimulus(OP_SET_BP, 32'h100, 2'd2, "setbp2");
    applyStimulus(OP_STEP, 32'd100, 2'd0, "step100");
    nextCycle();
    nextCycle();
    checkOutput("step100_cpu_en", 32'(cpuEn), 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("midrst_cpu_en", 32'(cpuEn), 32'd0);
    checkOutput("midrst_halted", 32'(halted), 32'd1);
    checkOutput("midrst_cause", 32'(haltCause), 32'(CAUSE_RESET));
    repeat (2) nextCycle();
    resetN = 1'b1;
    #1;

    // Old breakpoints (0x10, target, 0x100) must be gone.
    applyStimulus(OP_RUN, 32'h0, 2'd0, "run4");
    repeat (80) nextCycle();
    checkOutput("run4_pc", pcOut, 32'd320);
    checkOutput("run4_halted", 32'(halted), 32'd0);
    applyStimulus(OP_HALT, 32'h0, 2'd0, "halt2");
    checkOutput("halt2_cause", 32'(haltCause), 32'(CAUSE_HALT_CMD));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_debug_ctrl.md
# cpu_debug_ctrl

Debug/run controller that sequences the pipelined CPU (`cpu_pl`) from an external command port. It gates the CPU clock enable to provide run, halt, multi-cycle step and PC breakpoints. It also drives the shared debug address `m_rf_addr` to read back register-file or data-memory words through a valid/ready response port. It sits between the board I/O or host link and `cpu_pl`'s debug pins.

## Interface
Parameters:
- NUM_BP, 4, number of PC breakpoint slots (power of two, ≥2)
- BPW, $clog2(NUM_BP), breakpoint index width

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  3  0 RUN, 1 STEP, 2 HALT, 3 SET_BP, 4 CLR_BP, 5 READ_RF, 6 READ_MEM, 7 reserved (NOP)
- cmd_arg  in  32  STEP: cycle count; SET_BP: PC; READ_*: address in [7:0]
- cmd_idx  in  BPW  breakpoint slot for SET_BP/CLR_BP
- pc_out  in  32  CPU fetch PC
- cpu_en  out  1  CPU clock enable / advance
- m_rf_addr  out  8  debug read address to CPU
- rf_data  in  32  register-file read data (asynchronous read)
- m_data  in  32  data-memory read data (asynchronous read)
- rsp_valid  out  1  response pending
- rsp_ready  in  1  response consumed
- rsp_data  out  32  read result
- rsp_err  out  1  read rejected (CPU running)
- halted  out  1  CPU not advancing
- halt_cause  out  2  0 reset, 1 HALT cmd, 2 breakpoint, 3 step done

## Operation
- Reset values:
  - state HALT, cpu_en 0, halted 1, halt_cause 0
  - cmd_ready 1, rsp_valid 0, rsp_data 0, rsp_err 0
  - m_rf_addr 0, all breakpoint slots invalid, step counter 0, skip flag 0
- States: HALT, RUN, STEP, READ.
- cmd_ready = (state == HALT or RUN) and !rsp_valid.
- HALT state:
  - RUN → RUN, skip set.
  - STEP → STEP, counter = max(cmd_arg, 1).
  - READ_* → READ, m_rf_addr ← cmd_arg[7:0], source latched.
  - HALT/NOP/BP ops: stay.
- RUN state:
  - cpu_en = !(bp_hit & !skip); skip clears after first cycle with cpu_en=1.
  - bp_hit (pc_out equals any valid slot, with skip clear) → HALT, cause 2; cpu_en 0 that cycle.
  - HALT cmd → HALT, cause 1. HALT cmd and bp_hit in the same cycle → cause 1.
  - READ_* → rsp_valid 1, rsp_err 1, rsp_data 0; stay RUN.
  - RUN/STEP ignored (consumed).
- STEP state:
  - cpu_en 1 each cycle; counter decrements.
  - Breakpoints are ignored on the first step cycle and checked afterwards (hit → HALT, cause 2).
  - Counter reaching 1 while enabled → HALT, cause 3. Count 2^32−1 is legal, no wrap.
- READ state: one cycle. rsp_data ← rf_data or m_data, rsp_err 0, rsp_valid 1; → HALT.
- Response: rsp_valid holds until rsp_ready; rsp_data/rsp_err are stable while pending.
- SET_BP/CLR_BP are legal in HALT and RUN. A slot written in RUN takes effect the next cycle.
- halted = (state == HALT or READ).
- Reset mid-operation returns everything to reset values; breakpoints are cleared.

## Timing
- Command accepted at edge k; new state and cpu_en effect from cycle k+1.
- STEP N yields exactly N cycles of cpu_en=1 (fewer only on a breakpoint), starting at k+1.
- cpu_en is combinational on state, pc_out and slots, same cycle as pc_out.
- Read latency: accept at k, m_rf_addr valid k+1, rsp_valid from k+2.
- cmd_ready drops combinationally the cycle rsp_valid rises.

## Structure
- Package `dbg_pkg`: op encodings, state enum, halt_cause codes.
- Sub-module `bp_match`: NUM_BP slot registers (valid + 32-bit PC), write/clear port, one-hot/any-hit compare on pc_out.

## Test plan
- After reset release: halted=1, cpu_en=0, cause 0. RUN at cycle 3 → cpu_en=1 from cycle 4, halted=0.
- SET_BP idx0=0x0000_0010, then RUN from PC 0 → cpu_en falls in the cycle pc_out=0x10; halted, cause 2. RUN again → advances past 0x10 without re-halting.
- STEP arg=5 from HALT → exactly 5 cpu_en cycles, then cause 3. STEP arg=0 → 1 cycle.
- READ_RF arg=3 with rf_data=0x1234_5678 → m_rf_addr=3 next cycle; rsp_valid two cycles after accept with data 0x1234_5678. Hold rsp_ready=0 for 4 cycles → data stable and cmd_ready=0.
- READ_MEM during RUN → rsp_err=1, rsp_data=0, CPU keeps running. HALT in the same cycle as a bp hit → cause 1.
- Assert rst mid-STEP (count 100) → cpu_en=0 immediately; slots cleared, so a subsequent RUN does not stop at the old breakpoint.
